// File: rtl/fft4_frame_loader.sv
// fft4_frame_loader
//   Feeder for the 4-point FFT stage. Collects a serial valid/ready stream of
//   packed complex samples {re[31:16], im[15:0]} (passed through unmodified)
//   into 4-sample frames held in two ping-pong banks. It presents each frame
//   in parallel to the FFT and runs the start / done / rearm handshake.
//
// Ports
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_in_valid      input sample valid
//   o_in_ready      loader can accept a sample (low only when both banks full)
//   i_in_data       input sample
//   o_fft_frame     frame to FFT; element 0 = first sample accepted
//   o_fft_start     one-cycle start pulse
//   i_fft_done      FFT done level, only looked at in BUSY
//   o_fft_rst       active-low rearm to FFT
//   o_result_valid  one-cycle pulse: FFT outputs may be captured this cycle
//   o_timeout_err   sticky abort flag, cleared only by reset
//   o_frame_cnt     frames completed, wraps
//
// state   | meaning
// ARM     | fft_rst low for one cycle to rearm the FFT
// IDLE    | wait for a full bank, copy it to o_fft_frame and free the bank
// LAUNCH  | fft_start pulse
// BUSY    | wait for fft_done, abort after TIMEOUT cycles from the start pulse
// RELEASE | result_valid pulse with fft_rst low, frame counted

module fft4_frame_loader #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [WIDTH-1:0]      i_in_data,
    output logic [3:0][WIDTH-1:0] o_fft_frame,
    output logic                  o_fft_start,
    input  logic                  i_fft_done,
    output logic                  o_fft_rst,
    output logic                  o_result_valid,
    output logic                  o_timeout_err,
    output logic [CNT_W-1:0]      o_frame_cnt
);

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_bank [0:1][0:3];
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_wr_idx;
    logic [TW-1:0]    r_timer;
    logic             w_accept;
    logic             w_last_beat;
    logic             w_copy;
    logic             w_abort;

    assign o_in_ready  = !r_full[r_wr_bank];
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last_beat = w_accept && (r_wr_idx == 2'd3);
    assign w_copy      = (r_state == S_IDLE) && r_full[r_rd_bank];

    // A copy needs full[rd_bank] and a write needs !full[wr_bank], so the set
    // and the clear below can never target the same bank in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_copy) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_last_beat) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        unique case (r_state)
            S_ARM:     w_state_nxt = S_IDLE;
            S_IDLE:    if (w_copy) w_state_nxt = S_LAUNCH;
            S_LAUNCH:  w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (i_fft_done) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt = S_ARM;
                    w_abort     = 1'b1;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_ARM;
        endcase
    end

    // Sample storage carries no reset; the full flags decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_bank[r_wr_bank][r_wr_idx] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= 2'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_idx <= r_wr_idx + 2'd1;
            end
            if (w_last_beat) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_copy) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

    // Outputs are registered from the next state so each pulse lines up with
    // the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_ARM;
            o_fft_start    <= 1'b0;
            o_fft_rst      <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            o_fft_start    <= (w_state_nxt == S_LAUNCH);
            o_fft_rst      <= (w_state_nxt != S_ARM) && (w_state_nxt != S_RELEASE);
            o_result_valid <= (w_state_nxt == S_RELEASE);
        end
    end

    // The timer is zero in the LAUNCH cycle and counts through BUSY, so an
    // abort raises the error flag exactly TIMEOUT cycles after fft_start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (w_copy) begin
            r_timer <= '0;
        end else if ((r_state == S_LAUNCH) || (r_state == S_BUSY)) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fft_frame   <= '0;
            o_timeout_err <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            if (w_copy) begin
                o_fft_frame[0] <= r_bank[r_rd_bank][2'd0];
                o_fft_frame[1] <= r_bank[r_rd_bank][2'd1];
                o_fft_frame[2] <= r_bank[r_rd_bank][2'd2];
                o_fft_frame[3] <= r_bank[r_rd_bank][2'd3];
            end
            if (w_abort) begin
                o_timeout_err <= 1'b1;
            end
            if (r_state == S_RELEASE) begin
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
